seg_add: RTL and testbench

SEG_ADD -- requirements
Module: seg_add

---
 rtl/seg_add_pkg.sv | 14 +
 rtl/cla_slice.sv | 47 ++++
 rtl/seg_add.sv | 112 +++++++++++
 tb/tb_seg_add.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/seg_add_pkg.sv
// seg_add_pkg: shared definitions for the segmented adder.
//   state_t     - controller states (IDLE, RUN, DONE)
//   SEG_DEFAULT - default segment width in bits
package seg_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned SEG_DEFAULT = 4;

endpackage

// File: rtl/cla_slice.sv
// cla_slice: SEG-bit carry-lookahead adder slice.
// Ports:
//   x, y   - segment operands
//   ci     - carry into the slice LSB
//   sum    - segment sum
//   co     - carry out of the slice MSB
//   c_msb  - carry into the slice MSB (used for signed overflow)
module cla_slice #(
    parameter int unsigned SEG = 4
) (
    input  logic [SEG-1:0] x,
    input  logic [SEG-1:0] y,
    input  logic           ci,
    output logic [SEG-1:0] sum,
    output logic           co,
    output logic           c_msb
);

    logic [SEG-1:0] g;
    logic [SEG-1:0] p;
    logic [SEG:0]   c;

    assign g = x & y;
    assign p = x ^ y;

    // Each carry is the flattened lookahead sum of products:
    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]ci
    always_comb begin
        logic term;
        c    = '0;
        c[0] = ci;
        for (int unsigned i = 0; i < SEG; i++) begin
            c[i+1] = g[i];
            term   = p[i];
            for (int unsigned j = 0; j < i; j++) begin
                c[i+1] = c[i+1] | (term & g[i-1-j]);
                term   = term & p[i-1-j];
            end
            c[i+1] = c[i+1] | (term & ci);
        end
    end

    assign sum   = p ^ c[SEG-1:0];
    assign co    = c[SEG];
    assign c_msb = c[SEG-1];

endmodule

// File: rtl/seg_add.sv
// seg_add: multi-cycle adder/subtractor processing SEG bits per clock
// through a single reused cla_slice, LSB segment first.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   start      - request an operation (accepted in IDLE or DONE)
//   a, b       - operands, sampled only at the accepting edge
//   cin        - carry-in (add mode only)
//   sub        - 0: a+b+cin, 1: a-b
//   busy       - operation in progress
//   done       - one-cycle pulse, result valid
//   s          - sum/difference
//   cout       - carry out of MSB (sub: 1 = no borrow)
//   ovf        - two's-complement overflow
module seg_add
    import seg_add_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SEG   = SEG_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned N    = WIDTH / SEG;
    localparam int unsigned KW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] LAST = KW'(N - 1);

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_r, b_r, acc, acc_nx;
    logic [KW-1:0]    k;
    logic             carry;
    logic             accept;

    logic [SEG-1:0]   x, y, sum;
    logic             co, c_msb;

    // Only one slice exists; the segment index selects its operands.
    cla_slice #(.SEG(SEG)) u_slice (
        .x     (x),
        .y     (y),
        .ci    (carry),
        .sum   (sum),
        .co    (co),
        .c_msb (c_msb)
    );

    always_comb begin
        x      = a_r[k*SEG +: SEG];
        y      = b_r[k*SEG +: SEG];
        acc_nx = acc;
        acc_nx[k*SEG +: SEG] = sum;
    end

    assign accept = start && (state != RUN);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (k == LAST) state_nx = DONE;
            DONE:    state_nx = start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            acc   <= '0;
            k     <= '0;
            carry <= 1'b0;
            s     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                // Subtraction is folded into addition: a + ~b + 1.
                a_r   <= a;
                b_r   <= sub ? ~b : b;
                carry <= sub ? 1'b1 : cin;
                k     <= '0;
                acc   <= '0;
            end else if (state == RUN) begin
                acc   <= acc_nx;
                carry <= co;
                k     <= k + 1'b1;
                if (k == LAST) begin
                    s    <= acc_nx;
                    cout <= co;
                    ovf  <= co ^ c_msb;
                end
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_seg_add.sv
// tb_seg_add: self-checking bench for seg_add (WIDTH=16, SEG=4).
module tb_seg_add;

    logic        clk = 1'b0;
    logic        rst, start, cin, sub;
    logic [15:0] a, b;
    logic        busy, done, cout, ovf;
    logic [15:0] s;

    int checks   = 0;
    int failures = 0;

    seg_add #(.WIDTH(16), .SEG(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model from plain integer arithmetic.
    task automatic model(input logic [15:0] ai, input logic [15:0] bi,
                         input logic ci, input logic si,
                         output logic [15:0] es, output logic ec, output logic eo);
        int sa, sb, sv;
        int unsigned u;
        sa = int'($signed(ai));
        sb = int'($signed(bi));
        if (si) begin
            u  = 32'(ai) - 32'(bi);
            es = u[15:0];
            ec = (ai >= bi);
            sv = sa - sb;
        end else begin
            u  = 32'(ai) + 32'(bi) + 32'(ci);
            es = u[15:0];
            ec = u[16];
            sv = sa + sb + int'(ci);
        end
        eo = (sv > 32767) || (sv < -32768);
    endtask

    // Called at posedge+1; the next edge is the capture edge.
    task automatic launch(input logic [15:0] ai, input logic [15:0] bi,
                          input logic ci, input logic si);
        start = 1'b1; a = ai; b = bi; cin = ci; sub = si;
        @(posedge clk); #1;
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom);
        cin = 1'($urandom); sub = 1'($urandom);
    endtask

    // Runs edges 1..4 after a launch and checks timing and result.
    task automatic finish_op(input string tag, input logic [15:0] ai, input logic [15:0] bi,
                             input logic ci, input logic si);
        logic [15:0] es;
        logic ec, eo;
        model(ai, bi, ci, si, es, ec, eo);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            chk({tag, "_early_done"}, 32'(done), 32'd0);
        end
        @(posedge clk); #1;
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_off"}, 32'(busy), 32'd0);
        chk({tag, "_s"}, 32'(s), 32'(es));
        chk({tag, "_cout"}, 32'(cout), 32'(ec));
        chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic rc, rs;
        int dcount;

        rst = 1'b1; start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; sub = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", 32'(busy), 32'd0);

        launch(16'hFFFF, 16'h0001, 1'b0, 1'b0); finish_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("hold_s", 32'(s), 32'h0000);
        launch(16'h7FFF, 16'h0001, 1'b0, 1'b0); finish_op("povf", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        launch(16'h8000, 16'h0001, 1'b0, 1'b1); finish_op("novf", 16'h8000, 16'h0001, 1'b0, 1'b1);
        launch(16'h0003, 16'h0005, 1'b0, 1'b1); finish_op("borrow", 16'h0003, 16'h0005, 1'b0, 1'b1);
        launch(16'h1234, 16'h4321, 1'b1, 1'b0); finish_op("cin", 16'h1234, 16'h4321, 1'b1, 1'b0);
        chk("cin_abs", 32'(s), 32'h5556);
        launch(16'h0010, 16'h0003, 1'b1, 1'b1); finish_op("sub_ign_cin", 16'h0010, 16'h0003, 1'b1, 1'b1);

        // start during RUN is ignored
        launch(16'hA5A5, 16'h1111, 1'b0, 1'b0);
        @(posedge clk); #1;
        start = 1'b1; a = 16'h0F0F; b = 16'h7777; cin = 1'b1; sub = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("ign_early_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        chk("ign_done", 32'(done), 32'd1);
        chk("ign_s", 32'(s), 32'hB6B6);
        chk("ign_cout", 32'(cout), 32'd0);
        dcount = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        chk("ign_single_pulse", 32'(dcount), 32'd0);

        // back-to-back via start in DONE
        launch(16'h4000, 16'h4000, 1'b0, 1'b0); finish_op("b2b1", 16'h4000, 16'h4000, 1'b0, 1'b0);
        launch(16'h0001, 16'h0002, 1'b0, 1'b1);
        chk("b2b_busy_next", 32'(busy), 32'd1);
        finish_op("b2b2", 16'h0001, 16'h0002, 1'b0, 1'b1);

        // reset mid-run
        launch(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_s", 32'(s), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        chk("abort_ovf", 32'(ovf), 32'd0);
        dcount = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        chk("abort_no_done", 32'(dcount), 32'd0);
        launch(16'hBEEF, 16'h1234, 1'b1, 1'b0); finish_op("fresh", 16'hBEEF, 16'h1234, 1'b1, 1'b0);

        // randomized operations, some back-to-back
        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            if (i % 5 == 0) ra = 16'h8000 | ra;
            if (i % 7 == 0) rb = ra;
            launch(ra, rb, rc, rs);
            finish_op("rand", ra, rb, rc, rs);
            if ($urandom_range(0, 1) == 0) begin
                @(posedge clk); #1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
